// File: rtl/nios_pio_gen.sv
// nios_pio_gen: parametrised Avalon-MM general-purpose I/O port.
//
// Per-bit direction control, a synchronised input path, edge capture and a
// maskable, registered level interrupt. The top level builds tristate pads
// from pio_out/pio_oe.
//
// Optional feature: define PIO_BITSET_EN to enable the OUTSET (address 4) and
// OUTCLEAR (address 5) write-only registers for atomic single-bit updates of
// data_out. Without it, addresses 4/5 read 0 and ignore writes.
//
// Ports:
//   clk         system clock, the only clock
//   reset       synchronous, active-high reset
//   address     register word index (0 DATA, 1 DIRECTION, 2 IRQ_MASK,
//               3 EDGE_CAPTURE, 4 OUTSET, 5 OUTCLEAR)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, only [WIDTH-1:0] is used
//   readdata    read data, zero latency, upper bits always 0
//   pio_in      asynchronous pin input
//   pio_out     data_out register
//   pio_oe      direction register, 1 = drive pin
//   irq         registered level interrupt, active-high
module nios_pio_gen #(
   parameter int unsigned WIDTH       = 8,
   parameter logic [31:0] OUT_RESET   = 32'h0,
   parameter logic [31:0] DIR_RESET   = 32'h0,
   parameter int unsigned EDGE_TYPE   = 0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] pio_in,
   output logic [WIDTH-1:0] pio_out,
   output logic [WIDTH-1:0] pio_oe,
   output logic             irq
);

   localparam logic [2:0] SettleMax = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev_q;
   logic [2:0]       settle_q;
   logic             settled;

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             irq_q;

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] cap_clr;

   // Bits above WIDTH are deliberately ignored.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   assign wr_en   = chipselect & ~write_n;
   assign wr_data = writedata[WIDTH-1:0];
   assign sync    = sync_q[SYNC_STAGES-1];
   assign settled = (settle_q == SettleMax);

   // Gating edges until the pipeline has flushed hides the 0->1 step seen by
   // pins that were held high through reset.
   always_comb begin
      if (EDGE_TYPE == 1) begin
         edge_raw = ~sync & prev_q;
      end else if (EDGE_TYPE == 2) begin
         edge_raw = sync ^ prev_q;
      end else begin
         edge_raw = sync & ~prev_q;
      end
      edge_det = settled ? edge_raw : '0;
   end

   // Set wins over write-1-to-clear on the same bit.
   always_comb begin
      cap_clr = (wr_en && address == 3'd3) ? wr_data : '0;
      cap_d   = (cap_q & ~cap_clr) | edge_det;
   end

   always_comb begin
      data_out_d = data_out_q;
      if (wr_en) begin
         case (address)
            3'd0: data_out_d = wr_data;
`ifdef PIO_BITSET_EN
            3'd4: data_out_d = data_out_q | wr_data;
            3'd5: data_out_d = data_out_q & ~wr_data;
`endif
            default: ;
         endcase
      end
   end

   // Input synchroniser, previous sample and settle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         prev_q   <= '0;
         settle_q <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], pio_in};
         prev_q   <= sync;
         if (!settled) begin
            settle_q <= settle_q + 3'd1;
         end
      end
   end

   // Control/status registers and interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= OUT_RESET[WIDTH-1:0];
         dir_q      <= DIR_RESET[WIDTH-1:0];
         mask_q     <= '0;
         cap_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         cap_q      <= cap_d;
         irq_q      <= |(cap_q & mask_q);
         if (wr_en && address == 3'd1) begin
            dir_q <= wr_data;
         end
         if (wr_en && address == 3'd2) begin
            mask_q <= wr_data;
         end
      end
   end

   // DATA returns the synchronised pins regardless of direction.
   always_comb begin
      readdata = '0;
      case (address)
         3'd0:    readdata[WIDTH-1:0] = sync;
         3'd1:    readdata[WIDTH-1:0] = dir_q;
         3'd2:    readdata[WIDTH-1:0] = mask_q;
         3'd3:    readdata[WIDTH-1:0] = cap_q;
         default: ;
      endcase
   end

   assign pio_out = data_out_q;
   assign pio_oe  = dir_q;
   assign irq     = irq_q;

endmodule

// File: doc/nios_pio_gen.md
Name: nios_pio_gen

Overview:
- Parametrised general-purpose I/O port on the Avalon-MM bus. It is the successor to the fixed 8-bit output-only PIO in the i2c_nios system.
- Adds per-bit direction control, a synchronised input path, edge capture and a maskable level IRQ.
- Sits between the Nios II data master and board pins, for example bit-banged I2C SDA/SCL or status LEDs.
- The top level builds tristate pads from pio_out and pio_oe.

Parameters:
- WIDTH, 8: number of I/O bits, 1..32.
- OUT_RESET, 0: reset value of the data_out register.
- DIR_RESET, 0: reset value of the direction register; 1 = output.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register word index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; zero read latency (combinational mux).
- pio_in  in  WIDTH  asynchronous pin input.
- pio_out  out  WIDTH  data_out register.
- pio_oe  out  WIDTH  direction register; 1 = drive pin.
- irq  out  1  registered interrupt, level, active-high.

Behaviour:
- Write occurs when chipselect=1 and write_n=0, on the rising edge of clk. Only writedata[WIDTH-1:0] is used. Reads have no side effects.
- Register map:
  - 0 DATA: read returns the synchronised pin value; write loads data_out.
  - 1 DIRECTION: read/write.
  - 2 IRQ_MASK: read/write; resets to 0.
  - 3 EDGE_CAPTURE: read; writing 1 clears a bit, writing 0 leaves it.
  - 4/5: OUTSET/OUTCLEAR, see Optional Feature.
  - 6, 7, and 4/5 when the feature is out: read 0, writes ignored.
- readdata[31:WIDTH] is always 0.
- Reset values:
  - data_out = OUT_RESET, direction = DIR_RESET.
  - irq_mask = 0, edge_capture = 0, irq = 0.
  - Synchroniser flops and the previous-sample flop = 0.
  - Settle counter = 0.
- Synchroniser: a SYNC_STAGES-deep flop chain per bit produces sync. prev is sync delayed by one cycle.
- Edge detect is combinational from sync and prev:
  - EDGE_TYPE 0: sync & ~prev.
  - EDGE_TYPE 1: ~sync & prev.
  - EDGE_TYPE 2: sync ^ prev.
- Settle counter:
  - Counts 0..SYNC_STAGES+1 after reset, then saturates.
  - Edge detect is gated off until the counter saturates, which suppresses false edges from pins held high through reset.
  - Reset asserted mid-operation restarts the counter and clears all state in the same cycle.
- Latency: let E0 be the clock edge at which pio_in first samples a new value.
  - DATA read reflects the new value after E(SYNC_STAGES-1).
  - The edge_capture bit is set at E(SYNC_STAGES).
  - irq rises at E(SYNC_STAGES+1).
- irq (registered) = OR of (edge_capture & irq_mask).
  - Clearing a capture bit or its mask bit deasserts irq one edge after the write.
- Simultaneous events:
  - A new edge and a write-1-clear on the same bit in the same cycle leave the bit set; set wins.
  - Other bits clear normally.
- DATA read ignores the direction register: an output bit reads back the pin through the synchroniser, not data_out.
- Writing DATA while pio_oe=0 still updates data_out; the pin is not driven until the direction bit is set.

Optional Feature:
- Macro: PIO_BITSET_EN.
- Defined:
  - Address 4 OUTSET: data_out <= data_out | wd.
  - Address 5 OUTCLEAR: data_out <= data_out & ~wd.
  - Both take effect in one cycle, are write-only and read 0.
  - This gives atomic single-bit updates for bit-banging.
- Not defined: addresses 4/5 read 0 and writes are ignored; the data_out logic has only the DATA write path.

Test Plan:
- Reset then read all registers (WIDTH=8, OUT_RESET=0xA5, DIR_RESET=0x0F) -> DATA=sync pins, DIRECTION=0x0F, IRQ_MASK=0, EDGE_CAPTURE=0. Outputs after reset: pio_out=0xA5, pio_oe=0x0F, irq=0.
- Hold pio_in=0xFF through reset and release -> EDGE_CAPTURE stays 0 and irq stays 0 for 20 cycles (settle gating).
- EDGE_TYPE=0, IRQ_MASK=0x04, pio_in bit2 0->1 at E0 -> EDGE_CAPTURE=0x04 at E2, irq=1 at E3. Write 0x04 to address 3 -> irq=0 one edge later.
- Rising edge on bit 2 arrives in the same cycle as a write-1-clear of bit 2 -> EDGE_CAPTURE bit2 remains 1 and irq stays 1.
- PIO_BITSET_EN defined, DATA=0x30: write 0x01 to address 4 -> pio_out=0x31; write 0x20 to address 5 -> pio_out=0x11. Macro undefined: same writes leave pio_out=0x30.
- WIDTH=32, write 0xDEADBEEF to DATA with DIRECTION=0xFFFFFFFF and pio_in looped back to pio_out -> DATA reads 0xDEADBEEF after SYNC_STAGES cycles.
